// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

    localparam int MAX_REQ  = 32;
    localparam int MAX_ID_W = 5;

    // Arbitration policy selected by the mode input.
    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Controller states: waiting for requests, or a grant is being held.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // One-hot to index: each index bit is the OR of every one-hot position
    // whose index has that bit set. Zero input yields zero.
    function automatic logic [MAX_ID_W-1:0] onehot2id(input logic [MAX_REQ-1:0] oh);
        logic [MAX_ID_W-1:0] id;
        logic [31:0]         pos;
        id = '0;
        for (int b = 0; b < MAX_ID_W; b++) begin
            for (int i = 0; i < MAX_REQ; i++) begin
                pos   = i;
                id[b] = id[b] | (oh[i] & pos[b]);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational circular priority picker. Under round-robin the search
// starts just above last_id and wraps; under fixed priority bit 0 wins.
// The request vector is doubled so the wrap-around falls out of a single
// lowest-set-bit search over the masked double-width vector.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    input  logic             mode,
    output logic [N_REQ-1:0] winner
);

    logic [2*N_REQ-1:0] dbl_req_s;
    logic [2*N_REQ-1:0] mask_s;
    logic [2*N_REQ-1:0] masked_s;
    logic [2*N_REQ-1:0] lowest_s;

    // Mask the doubled request vector, isolate its lowest set bit and fold both halves.
    always_comb begin
        dbl_req_s = {req, req};
        if (arb_mode_e'(mode) == ARB_FIXED) begin
            mask_s = {(2*N_REQ){1'b1}};
        end else begin
            // Keep only positions strictly above last_id; the upper copy
            // supplies the wrapped (unmasked) fallback.
            mask_s = {(2*N_REQ){1'b1}} << (int'(last_id) + 32'sd1);
        end
        masked_s = dbl_req_s & mask_s;
        lowest_s = masked_s & (~masked_s + {{(2*N_REQ-1){1'b0}}, 1'b1});
        winner   = lowest_s[N_REQ-1:0] | lowest_s[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: two-state controller, per-grant hold budget,
// round-robin pointer and fully registered grant outputs.
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int WEIGHT_W = 4,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_REQ-1:0]          req,
    input  logic                      lock,
    input  logic                      mode,
    input  logic [N_REQ*WEIGHT_W-1:0] weights,
    output logic                      gnt,
    output logic [N_REQ-1:0]          gnt_vec,
    output logic [ID_W-1:0]           gnt_id,
    output logic                      preempt
);

    // Requester 0 wins the first round-robin pick after reset.
    localparam logic [ID_W-1:0]     LAST_RST = ID_W'(N_REQ - 1);
    localparam logic [WEIGHT_W-1:0] HOLD_ONE = WEIGHT_W'(32'd1);

    arb_state_e          state_r;
    arb_state_e          state_s;
    logic [WEIGHT_W-1:0] hold_cnt_r;
    logic [WEIGHT_W-1:0] hold_cnt_s;
    logic [ID_W-1:0]     last_id_r;
    logic [ID_W-1:0]     last_id_s;

    logic                gnt_s;
    logic [N_REQ-1:0]    gnt_vec_s;
    logic [ID_W-1:0]     gnt_id_s;
    logic                preempt_s;

    logic [N_REQ-1:0]    pick_vec_s;
    logic [MAX_REQ-1:0]  pick_oh_s;
    logic [ID_W-1:0]     pick_id_s;
    logic [WEIGHT_W-1:0] pick_weight_s;
    logic                owner_req_s;
    logic                others_req_s;
    logic                expire_s;

    arb_rr_pick #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req),
        .last_id (last_id_r),
        .mode    (mode),
        .winner  (pick_vec_s)
    );

    // Decode the picker result into an index and fetch that requester's budget.
    always_comb begin
        pick_oh_s                = '0;
        pick_oh_s[N_REQ-1:0]     = pick_vec_s;
        pick_id_s                = ID_W'(onehot2id(pick_oh_s));
        pick_weight_s            = weights[int'(pick_id_s)*WEIGHT_W +: WEIGHT_W];
    end

    // Owner/competitor status; a budget of zero never reaches one, so it never expires.
    always_comb begin
        owner_req_s  = |(req & gnt_vec);
        others_req_s = |(req & ~gnt_vec);
        expire_s     = (hold_cnt_r == HOLD_ONE) && !lock && others_req_s;
    end

    // Next-state and next-output logic for the grant controller.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        last_id_s  = last_id_r;
        gnt_s      = gnt;
        gnt_vec_s  = gnt_vec;
        gnt_id_s   = gnt_id;
        preempt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s    = GRANT;
                    gnt_s      = 1'b1;
                    gnt_vec_s  = pick_vec_s;
                    gnt_id_s   = pick_id_s;
                    last_id_s  = pick_id_s;
                    hold_cnt_s = pick_weight_s;
                end else begin
                    gnt_s      = 1'b0;
                    gnt_vec_s  = '0;
                end
            end
            GRANT: begin
                if (!owner_req_s) begin
                    // Owner finished: release without a preemption pulse.
                    state_s    = IDLE;
                    gnt_s      = 1'b0;
                    gnt_vec_s  = '0;
                end else if (expire_s) begin
                    state_s    = IDLE;
                    gnt_s      = 1'b0;
                    gnt_vec_s  = '0;
                    preempt_s  = 1'b1;
                end else if (hold_cnt_r > HOLD_ONE) begin
                    hold_cnt_s = hold_cnt_r - HOLD_ONE;
                end else begin
                    // Saturate at one (or stay at zero for unlimited hold).
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                state_s    = IDLE;
                gnt_s      = 1'b0;
                gnt_vec_s  = '0;
            end
        endcase
    end

    // State, budget, pointer and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            hold_cnt_r <= '0;
            last_id_r  <= LAST_RST;
            gnt        <= 1'b0;
            gnt_vec    <= '0;
            gnt_id     <= '0;
            preempt    <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            last_id_r  <= last_id_s;
            gnt        <= gnt_s;
            gnt_vec    <= gnt_vec_s;
            gnt_id     <= gnt_id_s;
            preempt    <= preempt_s;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural reference model.
module tb_wrr_arbiter;

    localparam int N_REQ    = 4;
    localparam int WEIGHT_W = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic        lock;
    logic        mode;
    logic [15:0] weights;
    logic        gnt;
    logic [3:0]  gnt_vec;
    logic [1:0]  gnt_id;
    logic        preempt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit m_gnt;
    int m_owner;
    int m_last;
    int m_held;
    int m_w;
    bit m_pre;

    wrr_arbiter #(
        .N_REQ    (N_REQ),
        .WEIGHT_W (WEIGHT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .lock     (lock),
        .mode     (mode),
        .weights  (weights),
        .gnt      (gnt),
        .gnt_vec  (gnt_vec),
        .gnt_id   (gnt_id),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        req     = 4'b0000;
        lock    = 1'b0;
        mode    = 1'b0;
        weights = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Advance the reference model by one clock using the current inputs.
    task automatic model_step();
        int win;
        int others;
        m_pre = 1'b0;
        if (!m_gnt) begin
            if (req != 4'b0000) begin
                win = -1;
                if (mode) begin
                    for (int i = N_REQ - 1; i >= 0; i--) if (req[i]) win = i;
                end else begin
                    for (int k = N_REQ; k >= 1; k--) if (req[(m_last + k) % N_REQ]) win = (m_last + k) % N_REQ;
                end
                m_gnt   = 1'b1;
                m_owner = win;
                m_last  = win;
                m_w     = int'((weights >> (win * WEIGHT_W)) & 16'h000F);
                m_held  = 1;
            end
        end else begin
            others = 0;
            for (int i = 0; i < N_REQ; i++) if (req[i] && i != m_owner) others++;
            if (!req[m_owner]) begin
                m_gnt = 1'b0;
            end else if (m_w != 0 && m_held >= m_w && !lock && others > 0) begin
                m_gnt = 1'b0;
                m_pre = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (gnt !== 1'b0 || gnt_vec !== 4'b0000 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: gnt=%b vec=%b id=%0d pre=%b, expected all zero", gnt, gnt_vec, gnt_id, preempt);
        end
        req = 4'b1111;
        tick();
        n_checks++;
        if (gnt !== 1'b1 || gnt_id !== 2'd0 || gnt_vec !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_first_pick: gnt=%b id=%0d vec=%b, expected 1 0 0001", gnt, gnt_id, gnt_vec);
        end
        tick();
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 1'b0 || gnt_vec !== 4'b0000 || preempt !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: gnt=%b vec=%b pre=%b, expected 0 0000 0", gnt, gnt_vec, preempt);
        end
    endtask

    task automatic test_rr_fairness();
        int         exp_ids [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_vec;
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_vec = 4'b0001 << exp_ids[n];
            tick();
            n_checks++;
            if (gnt !== 1'b1 || gnt_id !== 2'(exp_ids[n]) || gnt_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL rr_grant[%0d]: gnt=%b id=%0d vec=%b, expected 1 %0d %b", n, gnt, gnt_id, gnt_vec, exp_ids[n], exp_vec);
            end
            tick();
            n_checks++;
            if (gnt !== 1'b1 || gnt_id !== 2'(exp_ids[n])) begin
                n_errors++;
                $display("FAIL rr_hold[%0d]: gnt=%b id=%0d, expected 1 %0d", n, gnt, gnt_id, exp_ids[n]);
            end
            req[exp_ids[n]] = 1'b0;
            tick();
            n_checks++;
            if (gnt !== 1'b0 || gnt_vec !== 4'b0000) begin
                n_errors++;
                $display("FAIL rr_gap[%0d]: gnt=%b vec=%b, expected 0 0000", n, gnt, gnt_vec);
            end
            req[exp_ids[n]] = 1'b1;
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        mode = 1'b1;
        req  = 4'b1010;
        tick();
        n_checks++;
        if (gnt !== 1'b1 || gnt_id !== 2'd1) begin
            n_errors++;
            $display("FAIL fixed_first: gnt=%b id=%0d, expected 1 1", gnt, gnt_id);
        end
        req = 4'b1011;
        repeat (2) tick();
        n_checks++;
        if (gnt !== 1'b1 || gnt_id !== 2'd1) begin
            n_errors++;
            $display("FAIL fixed_hold: gnt=%b id=%0d, expected 1 1", gnt, gnt_id);
        end
        req = 4'b1001;
        tick();
        n_checks++;
        if (gnt !== 1'b0) begin
            n_errors++;
            $display("FAIL fixed_release: gnt=%b, expected 0", gnt);
        end
        tick();
        n_checks++;
        if (gnt !== 1'b1 || gnt_id !== 2'd0 || gnt_vec !== 4'b0001) begin
            n_errors++;
            $display("FAIL fixed_next: gnt=%b id=%0d vec=%b, expected 1 0 0001", gnt, gnt_id, gnt_vec);
        end
    endtask

    task automatic test_weighted_preempt();
        int pulses;
        do_reset();
        weights = 16'h0300;
        req     = 4'b0100;
        tick();
        req = 4'b0101;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (gnt !== 1'b1 || gnt_id !== 2'd2 || preempt !== 1'b0) begin
                n_errors++;
                $display("FAIL wt_hold[%0d]: gnt=%b id=%0d pre=%b, expected 1 2 0", c, gnt, gnt_id, preempt);
            end
        end
        tick();
        n_checks++;
        if (gnt !== 1'b0 || preempt !== 1'b1) begin
            n_errors++;
            $display("FAIL wt_expire: gnt=%b pre=%b, expected 0 1", gnt, preempt);
        end
        pulses = 1;
        tick();
        if (preempt === 1'b1) pulses++;
        n_checks++;
        if (gnt !== 1'b1 || gnt_id !== 2'd0 || pulses != 1) begin
            n_errors++;
            $display("FAIL wt_next: gnt=%b id=%0d pulses=%0d, expected 1 0 1", gnt, gnt_id, pulses);
        end
    endtask

    task automatic test_lock();
        do_reset();
        weights = 16'h0300;
        req     = 4'b0100;
        tick();
        req  = 4'b0101;
        lock = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (gnt !== 1'b1 || gnt_id !== 2'd2 || preempt !== 1'b0) begin
                n_errors++;
                $display("FAIL lock_hold[%0d]: gnt=%b id=%0d pre=%b, expected 1 2 0", c, gnt, gnt_id, preempt);
            end
        end
        lock = 1'b0;
        tick();
        n_checks++;
        if (gnt !== 1'b0 || preempt !== 1'b1) begin
            n_errors++;
            $display("FAIL lock_release: gnt=%b pre=%b, expected 0 1", gnt, preempt);
        end
        tick();
        n_checks++;
        if (gnt !== 1'b1 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
            n_errors++;
            $display("FAIL lock_next: gnt=%b id=%0d pre=%b, expected 1 0 0", gnt, gnt_id, preempt);
        end
    endtask

    task automatic test_corners();
        do_reset();
        weights = 16'h0300;
        req     = 4'b0100;
        tick();
        req = 4'b0101;
        repeat (2) tick();
        req = 4'b0001;
        tick();
        n_checks++;
        if (gnt !== 1'b0 || preempt !== 1'b0) begin
            n_errors++;
            $display("FAIL drop_on_expiry: gnt=%b pre=%b, expected 0 0", gnt, preempt);
        end
        tick();
        n_checks++;
        if (gnt !== 1'b1 || gnt_id !== 2'd0) begin
            n_errors++;
            $display("FAIL drop_next: gnt=%b id=%0d, expected 1 0", gnt, gnt_id);
        end
        do_reset();
        weights = 16'h0010;
        req     = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (gnt !== 1'b1 || gnt_id !== 2'd1 || preempt !== 1'b0) begin
                n_errors++;
                $display("FAIL single_w1[%0d]: gnt=%b id=%0d pre=%b, expected 1 1 0", c, gnt, gnt_id, preempt);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_vec;
        do_reset();
        m_gnt   = 1'b0;
        m_owner = 0;
        m_last  = N_REQ - 1;
        m_held  = 0;
        m_w     = 0;
        m_pre   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_REQ; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 5) == 0) lock = ~lock;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ((c % 64) == 0) begin
                for (int i = 0; i < N_REQ; i++) weights[i*WEIGHT_W +: WEIGHT_W] = 4'($urandom_range(0, 4));
            end
            model_step();
            tick();
            exp_vec = m_gnt ? (4'b0001 << m_owner) : 4'b0000;
            n_checks++;
            if (gnt !== m_gnt || gnt_vec !== exp_vec || preempt !== m_pre) begin
                n_errors++;
                $display("FAIL rand_out[%0d]: gnt=%b vec=%b pre=%b, expected %b %b %b", c, gnt, gnt_vec, preempt, m_gnt, exp_vec, m_pre);
            end
            n_checks++;
            if (gnt_id !== 2'(m_owner)) begin
                n_errors++;
                $display("FAIL rand_id[%0d]: id=%0d, expected %0d", c, gnt_id, m_owner);
            end
            n_checks++;
            if (!$onehot0(gnt_vec) || gnt !== (|gnt_vec)) begin
                n_errors++;
                $display("FAIL rand_onehot[%0d]: gnt=%b vec=%b, expected one-hot vec matching gnt", c, gnt, gnt_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_weighted_preempt();
        test_lock();
        test_corners();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
